// File: rtl/mul_pkg.sv
// Shared constants and types for the radix-4 Booth sequential multiplier.
// Optional unsigned mode is enabled by defining MUL_UNSIGNED_EN.
package mul_pkg;

   localparam int unsigned MUL_WIDTH = 32;

   // One Booth digit per iteration: WIDTH+2 extended bits need WIDTH/2+1 digits.
   function automatic int unsigned niter(input int unsigned w);
      return w / 2 + 1;
   endfunction

   localparam int unsigned NITER = niter(MUL_WIDTH);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   typedef struct packed {
      logic neg;
      logic one;
      logic two;
   } booth_sel_t;

   localparam booth_sel_t BOOTH_ZERO = booth_sel_t'(3'b000);
   localparam booth_sel_t BOOTH_POS1 = booth_sel_t'(3'b010);
   localparam booth_sel_t BOOTH_POS2 = booth_sel_t'(3'b001);
   localparam booth_sel_t BOOTH_NEG1 = booth_sel_t'(3'b110);
   localparam booth_sel_t BOOTH_NEG2 = booth_sel_t'(3'b101);

endpackage

// File: rtl/booth_mul_seq_enc.sv
// Radix-4 Booth recoder: 3-bit multiplier window to {neg, one, two} selects.
module booth_r4_enc
   import mul_pkg::*;
(
   input  logic [2:0] win_i,
   output booth_sel_t sel_o_c
);

   always_comb begin
      sel_o_c = BOOTH_ZERO;
      case (win_i)
         3'b001, 3'b010: sel_o_c = BOOTH_POS1;
         3'b011:         sel_o_c = BOOTH_POS2;
         3'b100:         sel_o_c = BOOTH_NEG2;
         3'b101, 3'b110: sel_o_c = BOOTH_NEG1;
         default:        sel_o_c = BOOTH_ZERO;
      endcase
   end

endmodule

// File: rtl/booth_mul_seq.sv
// Sequential signed WIDTHxWIDTH multiplier, one radix-4 Booth digit per clock.
// Define MUL_UNSIGNED_EN to add the is_unsigned operand-mode input.
module booth_mul_seq
   import mul_pkg::*;
#(
   parameter int unsigned WIDTH = MUL_WIDTH
)
(
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
`ifdef MUL_UNSIGNED_EN
   input  logic             is_unsigned,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] product_hi,
   output logic [WIDTH-1:0] product_lo
);

   localparam int unsigned XW    = WIDTH + 2;
   localparam int unsigned MW    = WIDTH + 3;
   localparam int unsigned AW    = 2 * WIDTH + 4;
   localparam int unsigned PW    = 2 * WIDTH;
   localparam int unsigned NIT   = niter(WIDTH);
   localparam int unsigned CW    = $clog2(NIT + 1);

   logic [1:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [AW-1:0] acc_q, acc_d;
   logic [AW-1:0] mcand_q, mcand_d;
   logic [MW-1:0] mplr_q, mplr_d;
   logic [PW-1:0] prod_q, prod_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;

   logic          sgn_c;
   logic [XW-1:0] a_ext_c, b_ext_c;
   booth_sel_t    sel_c;
   logic [AW-1:0] pp_mag_c, pp_c, acc_sum_c;

`ifdef MUL_UNSIGNED_EN
   assign sgn_c = ~is_unsigned;
`else
   assign sgn_c = 1'b1;
`endif

   // Operand extension: sign bit replicated only in signed mode.
   assign a_ext_c = {{2{a[WIDTH-1] & sgn_c}}, a};
   assign b_ext_c = {{2{b[WIDTH-1] & sgn_c}}, b};

   booth_r4_enc u_enc (
      .win_i   (mplr_q[2:0]),
      .sel_o_c (sel_c)
   );

   // Partial product from the recoded digit; the multiplicand is pre-weighted.
   always_comb begin
      pp_mag_c = '0;
      if (sel_c.two) begin
         pp_mag_c = {mcand_q[AW-2:0], 1'b0};
      end else if (sel_c.one) begin
         pp_mag_c = mcand_q;
      end
      pp_c      = sel_c.neg ? (~pp_mag_c + AW'(1)) : pp_mag_c;
      acc_sum_c = acc_q + pp_c;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      mcand_d = mcand_q;
      mplr_d  = mplr_q;
      prod_d  = prod_q;
      busy_d  = busy_q;
      done_d  = 1'b0;

      case (state_q)
         ST_RUN: begin
            acc_d   = acc_sum_c;
            mcand_d = {mcand_q[AW-3:0], 2'b00};
            mplr_d  = {{2{mplr_q[MW-1]}}, mplr_q[MW-1:2]};
            cnt_d   = cnt_q + CW'(1);
            if (cnt_q == CW'(NIT - 1)) begin
               state_d = ST_DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               prod_d  = acc_sum_c[PW-1:0];
            end
         end
         default: begin
            // IDLE and DONE both accept a new request, giving back-to-back issue.
            if (start) begin
               state_d = ST_RUN;
               busy_d  = 1'b1;
               cnt_d   = '0;
               acc_d   = '0;
               mcand_d = {{(AW - XW){a_ext_c[XW-1]}}, a_ext_c};
               mplr_d  = {b_ext_c, 1'b0};
            end else begin
               state_d = ST_IDLE;
               busy_d  = 1'b0;
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         acc_q   <= '0;
         mcand_q <= '0;
         mplr_q  <= '0;
         prod_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         mcand_q <= mcand_d;
         mplr_q  <= mplr_d;
         prod_q  <= prod_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign busy       = busy_q;
   assign done       = done_q;
   assign product_hi = prod_q[PW-1:WIDTH];
   assign product_lo = prod_q[WIDTH-1:0];

endmodule

// File: tb/tb_booth_mul_seq.sv
// Scoreboard bench for booth_mul_seq: directed corner cases plus random vectors.
// Unsigned-mode vectors are added when MUL_UNSIGNED_EN is defined.
module tb_booth_mul_seq;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [31:0] a, b;
   logic        is_uns;
   logic        busy, done;
   logic [31:0] product_hi, product_lo;

   int          checks = 0;
   int          errors = 0;
   logic [63:0] exp_q[$];
   logic [63:0] last_prod;

   always #5 clk = ~clk;

   booth_mul_seq #(.WIDTH(32)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .a          (a),
      .b          (b),
`ifdef MUL_UNSIGNED_EN
      .is_unsigned(is_uns),
`endif
      .busy       (busy),
      .done       (done),
      .product_hi (product_hi),
      .product_lo (product_lo)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y,
                                           input logic uns);
      logic signed [63:0] sx, sy;
      if (uns) return {32'b0, x} * {32'b0, y};
      sx = {{32{x[31]}}, x};
      sy = {{32{y[31]}}, y};
      return 64'(sx * sy);
   endfunction

   // Scoreboard: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (!reset && done) begin
         if (exp_q.size() == 0) begin
            chk("spurious_done", 64'(done), 64'd0);
         end else begin
            chk("product", {product_hi, product_lo}, exp_q.pop_front());
         end
      end
   end

   // One operation; optionally re-pulses start during RUN at cycle `repulse`.
   task automatic do_op(input logic [31:0] ta, input logic [31:0] tb_, input logic uns,
                        input int repulse);
      int n;
      logic [63:0] e;
      e = ref_mul(ta, tb_, uns);
      @(negedge clk);
      a = ta; b = tb_; is_uns = uns; start = 1'b1;
      exp_q.push_back(e);
      @(negedge clk);
      start = 1'b0;
      a = ~ta; b = ~tb_;
      n = 1;
      chk("busy_run", 64'(busy), 64'd1);
      chk("prod_hold", {product_hi, product_lo}, last_prod);
      while (!done && n < 60) begin
         @(negedge clk);
         n++;
         start = (n == repulse);
      end
      start = 1'b0;
      chk("latency", 64'(n), 64'd18);
      last_prod = e;
   endtask

   initial begin
      int n;
      logic [31:0] ra, rb;
      logic        ru;
      reset = 1'b1; start = 1'b0; a = '0; b = '0; is_uns = 1'b0;
      last_prod = '0;
      repeat (3) @(negedge clk);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_prod", {product_hi, product_lo}, 64'd0);
      reset = 1'b0;

      do_op(32'd7, 32'hFFFF_FFFD, 1'b0, 0);
      chk("t1_value", last_prod, 64'hFFFF_FFFF_FFFF_FFEB);
      do_op(32'h8000_0000, 32'h8000_0000, 1'b0, 0);
      chk("t2_value", last_prod, 64'h4000_0000_0000_0000);
      do_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 5);
      chk("t3_value", last_prod, 64'hFFFF_FFFF_8000_0001);
      repeat (25) @(negedge clk);
      chk("t3_single_done", 64'(exp_q.size()), 64'd0);

      // Back-to-back with start held through done.
      @(negedge clk);
      a = 32'd3; b = 32'd5; start = 1'b1;
      exp_q.push_back(64'd15);
      n = 0;
      do begin @(negedge clk); n++; end while (!done && n < 60);
      chk("b2b_first_lat", 64'(n), 64'd18);
      a = 32'hFFFF_FFFC; b = 32'd6;
      exp_q.push_back(64'hFFFF_FFFF_FFFF_FFE8);
      n = 0;
      do begin @(negedge clk); n++; end while (!done && n < 60);
      chk("b2b_spacing", 64'(n), 64'd18);
      start = 1'b0;
      last_prod = 64'hFFFF_FFFF_FFFF_FFE8;
      repeat (3) @(negedge clk);

      // Reset in the middle of RUN aborts the operation.
      a = 32'd1234; b = 32'd99; start = 1'b1;
      exp_q.push_back(64'd122166);
      @(negedge clk);
      start = 1'b0;
      repeat (8) @(negedge clk);
      reset = 1'b1;
      #1;
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_done", 64'(done), 64'd0);
      chk("abort_prod", {product_hi, product_lo}, 64'd0);
      exp_q.delete();
      last_prod = '0;
      @(negedge clk);
      reset = 1'b0;
      repeat (25) @(negedge clk);
      do_op(32'd2, 32'd2, 1'b0, 0);
      chk("t5_value", last_prod, 64'd4);

`ifdef MUL_UNSIGNED_EN
      do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 0);
      chk("t6_value", last_prod, 64'hFFFF_FFFE_0000_0001);
      do_op(32'h8000_0000, 32'h8000_0000, 1'b1, 0);
`endif

      for (int i = 0; i < 1000; i++) begin
         ra = $urandom;
         rb = $urandom;
         if ((i % 16) == 0) ra = 32'h8000_0000;
         if ((i % 16) == 1) rb = 32'h0;
         if ((i % 16) == 2) rb = 32'hFFFF_FFFF;
`ifdef MUL_UNSIGNED_EN
         ru = 1'($urandom_range(0, 1));
`else
         ru = 1'b0;
`endif
         do_op(ra, rb, ru, 0);
      end

      repeat (5) @(negedge clk);
      chk("queue_empty", 64'(exp_q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
